// File: rtl/nibble_deser_pkg.sv
// Shared definitions for the nibble_deser serial-to-parallel converter.
//   out_state_e : encoding of the output holding-register FSM.
//   clog2       : width helper for BIT_CNT (returns at least 1).
package nibble_deser_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) result = i + 1;
    end
    return (result == 0) ? 1 : result;
  endfunction

endpackage

// File: rtl/nibble_shift_in.sv
// Shift register plus bit counter for nibble_deser.
// Ports:
//   i_clk, i_rst      : clock, synchronous active-high reset
//   i_sin, i_sin_valid: serial bit and its qualifier (always accepted)
//   i_sof             : start of frame, qualified by i_sin_valid
//   o_word            : word including the bit accepted this cycle
//   o_word_done       : strobe, o_word is complete this cycle
//   o_bit_cnt         : bits currently held in the partial word
module nibble_shift_in
  import nibble_deser_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MSB_FIRST = 1,
  parameter int unsigned CNT_W     = clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_sin,
  input  logic             i_sin_valid,
  input  logic             i_sof,
  output logic [WIDTH-1:0] o_word,
  output logic             o_word_done,
  output logic [CNT_W-1:0] o_bit_cnt
);

  logic [WIDTH-1:0] r_shift;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] w_base;
  logic [WIDTH-1:0] w_shifted;
  logic [CNT_W-1:0] w_cnt_base;
  logic             w_done;

  always_comb begin
    // SOF starts the new word from an empty register so SIN is its first bit.
    w_base     = i_sof ? '0 : r_shift;
    w_cnt_base = i_sof ? '0 : r_cnt;
    if (MSB_FIRST != 0) begin
      w_shifted = {w_base[WIDTH-2:0], i_sin};
    end else begin
      w_shifted = {i_sin, w_base[WIDTH-1:1]};
    end
    w_done = i_sin_valid && (w_cnt_base == CNT_W'(WIDTH - 1));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_sin_valid) begin
      r_shift <= w_shifted;
      r_cnt   <= w_done ? '0 : w_cnt_base + CNT_W'(1);
    end
  end

  assign o_word      = w_shifted;
  assign o_word_done = w_done;
  assign o_bit_cnt   = r_cnt;

endmodule

// File: rtl/nibble_deser.sv
// Serial-to-parallel converter: collects WIDTH serial bits into a word and
// presents it through a one-entry valid/ready holding register.
// Ports:
//   CLK, RST          : clock, synchronous active-high reset
//   SIN, SIN_VALID    : serial bit and its qualifier
//   SOF               : start of frame (discard partial word)
//   CLR_OVR           : clear the sticky OVERRUN flag
//   DOUT, DOUT_VALID  : held word and its valid flag
//   DOUT_READY        : consumer accepts DOUT
//   OVERRUN           : sticky, a completed word was dropped
//   BIT_CNT           : bits held in the partial word
module nibble_deser
  import nibble_deser_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     SIN,
  input  logic                     SIN_VALID,
  input  logic                     SOF,
  input  logic                     CLR_OVR,
  output logic [WIDTH-1:0]         DOUT,
  output logic                     DOUT_VALID,
  input  logic                     DOUT_READY,
  output logic                     OVERRUN,
  output logic [clog2(WIDTH)-1:0]  BIT_CNT
);

  localparam int unsigned CntW = clog2(WIDTH);

  logic [WIDTH-1:0] w_word;
  logic             w_word_done;
  logic [CntW-1:0]  w_bit_cnt;

  out_state_e       r_state;
  logic [WIDTH-1:0] r_dout;
  logic             r_overrun;

  nibble_shift_in #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST),
    .CNT_W    (CntW)
  ) u_shift_in (
    .i_clk      (CLK),
    .i_rst      (RST),
    .i_sin      (SIN),
    .i_sin_valid(SIN_VALID),
    .i_sof      (SOF),
    .o_word     (w_word),
    .o_word_done(w_word_done),
    .o_bit_cnt  (w_bit_cnt)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= ST_EMPTY;
      r_dout    <= '0;
      r_overrun <= 1'b0;
    end else begin
      unique case (r_state)
        ST_EMPTY: begin
          if (w_word_done) begin
            r_dout  <= w_word;
            r_state <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (w_word_done) begin
            // Consumer takes the old word as the new one lands: no bubble.
            if (DOUT_READY) r_dout <= w_word;
          end else if (DOUT_READY) begin
            r_state <= ST_EMPTY;
          end
        end
        default: r_state <= ST_EMPTY;
      endcase
      // A new drop wins over a simultaneous clear.
      if (r_state == ST_FULL && w_word_done && !DOUT_READY) begin
        r_overrun <= 1'b1;
      end else if (CLR_OVR) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign DOUT       = r_dout;
  assign DOUT_VALID = (r_state == ST_FULL);
  assign OVERRUN    = r_overrun;
  assign BIT_CNT    = w_bit_cnt;

endmodule

// File: tb/tb_nibble_deser.sv
// Directed bench for nibble_deser: one MSB-first and one LSB-first instance
// share the same stimulus.
module tb_nibble_deser;

  logic       clk;
  logic       rst;
  logic       sin;
  logic       sin_valid;
  logic       sof;
  logic       clr_ovr;
  logic       dout_ready;
  logic [3:0] dout_m, dout_l;
  logic       valid_m, valid_l;
  logic       ovr_m, ovr_l;
  logic [1:0] cnt_m, cnt_l;

  int n_tests = 0;
  int n_fail  = 0;

  nibble_deser #(.WIDTH(4), .MSB_FIRST(1)) u_msb (
    .CLK(clk), .RST(rst), .SIN(sin), .SIN_VALID(sin_valid), .SOF(sof),
    .CLR_OVR(clr_ovr), .DOUT(dout_m), .DOUT_VALID(valid_m),
    .DOUT_READY(dout_ready), .OVERRUN(ovr_m), .BIT_CNT(cnt_m)
  );

  nibble_deser #(.WIDTH(4), .MSB_FIRST(0)) u_lsb (
    .CLK(clk), .RST(rst), .SIN(sin), .SIN_VALID(sin_valid), .SOF(sof),
    .CLR_OVR(clr_ovr), .DOUT(dout_l), .DOUT_VALID(valid_l),
    .DOUT_READY(dout_ready), .OVERRUN(ovr_l), .BIT_CNT(cnt_l)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Waits for the falling edge (outputs reflect the last rising edge),
  // then applies inputs for the next rising edge.
  task automatic drive(input logic v, input logic b, input logic s);
    @(negedge clk);
    sin_valid = v;
    sin       = b;
    sof       = s;
  endtask

  // Sends w[3] first; returns with three bits sampled and the last pending.
  task automatic send_word(input logic [3:0] w);
    for (int i = 3; i >= 0; i--) drive(1'b1, w[i], 1'b0);
  endtask

  initial begin
    rst = 1'b1; sin = 1'b0; sin_valid = 1'b0; sof = 1'b0;
    clr_ovr = 1'b0; dout_ready = 1'b1;

    // Reset state
    drive(1'b0, 1'b0, 1'b0);
    check("rst_dout",  {28'd0, dout_m}, 32'd0);
    check("rst_valid", {31'd0, valid_m}, 32'd0);
    check("rst_ovr",   {31'd0, ovr_m}, 32'd0);
    check("rst_cnt",   {30'd0, cnt_m}, 32'd0);
    rst = 1'b0;

    // Basic word, READY high: VALID for exactly one cycle
    send_word(4'b1011);
    check("t1_cnt3",     {30'd0, cnt_m}, 32'd3);
    check("t1_pre_vld",  {31'd0, valid_m}, 32'd0);
    drive(1'b0, 1'b0, 1'b0);
    check("t1_valid",    {31'd0, valid_m}, 32'd1);
    check("t1_dout_msb", {28'd0, dout_m}, 32'hB);
    check("t1_dout_lsb", {28'd0, dout_l}, 32'hD);
    check("t1_cnt0",     {30'd0, cnt_m}, 32'd0);
    drive(1'b0, 1'b0, 1'b0);
    check("t1_vld_drop", {31'd0, valid_m}, 32'd0);

    // Backpressure and overrun
    dout_ready = 1'b0;
    send_word(4'b1011);
    drive(1'b1, 1'b0, 1'b0);
    check("t3_vld_w1",   {31'd0, valid_m}, 32'd1);
    check("t3_ovr_w1",   {31'd0, ovr_m}, 32'd0);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    check("t3_dout_hold", {28'd0, dout_m}, 32'hB);
    check("t3_dout_lsb",  {28'd0, dout_l}, 32'hD);
    check("t3_valid",     {31'd0, valid_m}, 32'd1);
    check("t3_ovr",       {31'd0, ovr_m}, 32'd1);
    check("t3_cnt_wrap",  {30'd0, cnt_m}, 32'd0);
    dout_ready = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    check("t3_vld_drop", {31'd0, valid_m}, 32'd0);
    check("t3_ovr_stky", {31'd0, ovr_m}, 32'd1);
    clr_ovr = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    clr_ovr = 1'b0;
    check("t3_ovr_clr",  {31'd0, ovr_m}, 32'd0);

    // Back-to-back, READY only on the second completion cycle
    dout_ready = 1'b0;
    send_word(4'b1111);
    drive(1'b1, 1'b0, 1'b0);
    check("t4_dout1",   {28'd0, dout_m}, 32'hF);
    check("t4_vld1",    {31'd0, valid_m}, 32'd1);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    dout_ready = 1'b1;
    check("t4_vld_mid", {31'd0, valid_m}, 32'd1);
    check("t4_dout_mid", {28'd0, dout_m}, 32'hF);
    drive(1'b0, 1'b0, 1'b0);
    check("t4_dout2",    {28'd0, dout_m}, 32'h1);
    check("t4_dout2_l",  {28'd0, dout_l}, 32'h8);
    check("t4_vld2",     {31'd0, valid_m}, 32'd1);
    check("t4_ovr",      {31'd0, ovr_m}, 32'd0);
    drive(1'b0, 1'b0, 1'b0);
    check("t4_vld_drop", {31'd0, valid_m}, 32'd0);

    // SOF realign; SOF without SIN_VALID is ignored
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    check("t5_cnt_noval", {30'd0, cnt_m}, 32'd2);
    drive(1'b1, 1'b1, 1'b0);
    check("t5_cnt_sof",   {30'd0, cnt_m}, 32'd1);
    check("t5_no_vld",    {31'd0, valid_m}, 32'd0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    check("t5_dout",   {28'd0, dout_m}, 32'h5);
    check("t5_dout_l", {28'd0, dout_l}, 32'hA);
    check("t5_valid",  {31'd0, valid_m}, 32'd1);
    drive(1'b0, 1'b0, 1'b0);
    check("t5_vld_drop", {31'd0, valid_m}, 32'd0);

    // Reset mid-word overrides a valid bit
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    check("t6_cnt_pre", {30'd0, cnt_m}, 32'd1);
    drive(1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b0);
    rst = 1'b0;
    check("t6_rst_cnt",  {30'd0, cnt_m}, 32'd0);
    check("t6_rst_dout", {28'd0, dout_m}, 32'd0);
    check("t6_rst_vld",  {31'd0, valid_m}, 32'd0);
    check("t6_rst_ovr",  {31'd0, ovr_m}, 32'd0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    check("t6_cnt3",     {30'd0, cnt_m}, 32'd3);
    check("t6_no_vld",   {31'd0, valid_m}, 32'd0);
    drive(1'b0, 1'b0, 1'b0);
    check("t6_dout",     {28'd0, dout_m}, 32'h9);
    check("t6_valid",    {31'd0, valid_m}, 32'd1);
    drive(1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nibble_deser.md
Name: nibble_deser

Overview:
- Serial-to-parallel converter; the inverse of the 4-input reducing gates in the mixed-language sample design.
- Collects WIDTH single-bit samples from a serial stream into one parallel word.
- Presents the word on a valid/ready output with a one-entry holding register.
- Sits between the serial stimulus source (C/PLI-driven or VHDL testbench) and the parallel consumer logic.

Parameters:
- WIDTH, 4, bits per output word; legal range 2..16.
- MSB_FIRST, 1, 1 = first received bit lands in DOUT[WIDTH-1]; 0 = first received bit lands in DOUT[0].

Ports:
- CLK  input  1  single clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- SIN  input  1  serial data bit.
- SIN_VALID  input  1  SIN is sampled this cycle; always accepted, no backpressure on the input side.
- SOF  input  1  start of frame; qualified by SIN_VALID.
- CLR_OVR  input  1  clears OVERRUN.
- DOUT  output  WIDTH  assembled word.
- DOUT_VALID  output  1  DOUT holds an unconsumed word.
- DOUT_READY  input  1  consumer accepts DOUT this cycle.
- OVERRUN  output  1  sticky flag: a completed word was dropped.
- BIT_CNT  output  clog2(WIDTH)  number of bits held in the partial word.

Behaviour:
- Clock and reset:
  - One clock, CLK.
  - RST is synchronous and active-high; it overrides all other inputs in its cycle.
  - Reset values: DOUT=0, DOUT_VALID=0, OVERRUN=0, BIT_CNT=0; the shift register is cleared.
- Reset mid-word or with a word pending: partial bits and the held word are discarded with no DOUT_VALID pulse.
- Bit accept:
  - When SIN_VALID=1, SIN is shifted into the shift register and BIT_CNT increments.
  - MSB_FIRST=1: shift left, insert at bit 0. MSB_FIRST=0: shift right, insert at bit WIDTH-1.
- SOF:
  - SOF=1 with SIN_VALID=1: the partial word is discarded and SIN becomes bit 0 of a new word (BIT_CNT=1 after the edge).
  - SOF=1 with SIN_VALID=0: ignored.
  - If WIDTH bits complete while SOF=1 (only possible for WIDTH=1, which is illegal), there is no special case.
- Word complete:
  - Occurs when a bit is accepted with BIT_CNT=WIDTH-1. BIT_CNT wraps to 0.
  - The full word, including the current bit, is offered to the output register.
- Output FSM, two states:
  - EMPTY to FULL: word complete. DOUT is loaded; DOUT_VALID=1 from the next cycle.
  - Latency: DOUT_VALID rises one cycle after the edge on which the last bit is sampled.
  - FULL to EMPTY: DOUT_READY=1 and no word completes in the same cycle.
  - FULL to FULL: DOUT_READY=1 and a word completes in the same cycle. The new word is loaded and DOUT_VALID stays 1 with no bubble.
  - FULL with DOUT_READY=0 and a word completing: the new word is dropped. DOUT keeps the old word, OVERRUN is set next cycle, and BIT_CNT still wraps to 0.
- While FULL and DOUT_READY=0, DOUT is stable.
- DOUT_READY while EMPTY: ignored. DOUT retains its last value; the value is don't-care for the consumer.
- OVERRUN:
  - Set by a dropped word; cleared by CLR_OVR or RST.
  - If CLR_OVR and a new drop occur in the same cycle, set wins.
- Throughput: at most one word per WIDTH SIN_VALID cycles, so there is never more than one completion per cycle.

Decomposition:
- Shared package nibble_deser_pkg:
  - output-state encoding (ST_EMPTY, ST_FULL);
  - function clog2 for the BIT_CNT width.
- Natural sub-module: nibble_shift_in, the shift register plus bit counter with SOF handling. It produces a word_done strobe and the word.
- The top level holds the output FSM, the holding register and OVERRUN.

Test Plan:
- MSB_FIRST=1, WIDTH=4, DOUT_READY=1, bits 1,0,1,1 on consecutive cycles -> DOUT=4'b1011, DOUT_VALID=1 for exactly one cycle, starting the cycle after the 4th bit.
- MSB_FIRST=0, same bits -> DOUT=4'b1101.
- Backpressure: DOUT_READY=0, send 4'b1011 then 4'b0110 -> DOUT stays 4'b1011, OVERRUN=1 after the 8th bit. Then READY=1 -> VALID drops; CLR_OVR -> OVERRUN=0.
- Back-to-back with READY pulsed on the completion cycle of the second word (bits 1,1,1,1 then 0,0,0,1) -> DOUT goes 4'b1111 then 4'b0001, VALID held high with no gap, OVERRUN=0.
- SOF realign: bits 1,1 then SOF with bits 0,1,0,1 -> single word 4'b0101 (MSB_FIRST=1); BIT_CNT reads 1 after the SOF bit.
- Reset mid-word: 2 bits then RST for one cycle, then 1,0,0,1 -> all outputs 0 during reset, next word 4'b1001, no spurious VALID.
